obstacle_alert_encoder: RTL and testbench
=========================================

# obstacle_alert_encoder

Parametrised N-channel obstacle-warning controller between the LIDAR proximity inputs and the speaker drivers. Each sensor input is synchronised, debounced and stretched by a hold timer. The block then drives either the single highest-priority speaker or every active speaker, with optional beep modulation. It supersedes the fixed 3-channel priority state machine and adds debounce, hold, multi-alert mode and an encoded active-channel report.

## Interface
Parameters:
- NUM_CH, 3: sensor/speaker channel count; legal range 1..16.
- DEBOUNCE, 4: consecutive synchronised cycles a new level must persist before it is accepted; minimum 1.
- HOLD, 8: cycles a channel's request stays asserted after its debounced input falls; 0 is legal.
- BEEP_HALF, 16: cycles per beep half-period; minimum 1.
- Derived ID_W = $clog2(NUM_CH+1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  reset, synchronous, active-low; takes priority over ena.
- ena  in  1  enable; 0 freezes all internal state and forces outputs to 0.
- sensor_in  in  NUM_CH  asynchronous proximity flags; 1 = obstacle close; bit 0 has highest priority.
- mode  in  1  0 = priority (one speaker), 1 = multi (all requesting speakers).
- beep_en  in  1  1 = gate speakers with the beep square wave; 0 = steady tone enable.
- speaker_out  out  NUM_CH  registered speaker enables.
- active_id  out  ID_W  registered winner index + 1; 0 = none. Always the priority winner, in either mode.
- alert  out  1  registered; 1 when any channel is requesting.

## Operation
Per channel c:
- **Synchroniser:** two flops, giving s[c]. Reset value 0.
- **Debounce:**
  - det[c] has reset value 0. Counter db[c] has reset value 0.
  - If s[c]==det[c], db[c] <= 0.
  - Otherwise, when db[c]==DEBOUNCE-1, det[c] <= s[c] and db[c] <= 0; else db[c] increments.
  - A glitch shorter than DEBOUNCE cycles is discarded; any mismatch gap restarts the count.
- **Hold:**
  - While det[c]==1, hold[c] <= HOLD; else if hold[c]!=0, hold[c] decrements. Reset value 0.
  - req[c] = det[c] | (hold[c]!=0), combinational.
  - Re-assertion during hold keeps req[c] high continuously; hold reloads.

Selection, combinational, registered into outputs:
- win = lowest index c with req[c]==1.
- mode 0: sel = one-hot(win).
- mode 1: sel = req.
- No requests: sel = 0, win_id = 0.

Beep generator:
- Counter bc (0..BEEP_HALF-1) and phase ph.
- When no req is set: bc <= 0, ph <= 1.
- Otherwise bc increments. On bc==BEEP_HALF-1, bc <= 0 and ph toggles.
- Each alert therefore starts on a high phase.

Output register, updated each ena cycle:
- speaker_out <= sel & {NUM_CH{ph | ~beep_en}}
- active_id <= win+1 (0 if none)
- alert <= |req

ena and reset:
- ena=0: synchronisers, counters, det, hold, bc and ph hold their values. Outputs are registered to 0 on that edge.
- On ena return, operation resumes from the frozen state.
- Reset, including mid-alert: all state and outputs are 0 on the edge after rst_n is sampled low; ph resets to 1.

Simultaneous events:
- Several channels qualifying on the same edge: priority picks the lowest index; multi mode drives all of them.
- A mode or beep_en change takes effect on the next output-register edge.

## Timing
Edge numbering: sensor_in changes before edge 1.
- s[c] valid after edge 2.
- det[c] changes at edge 2+DEBOUNCE.
- Outputs change at edge 3+DEBOUNCE, which is edge 7 at defaults.

Release:
- det falls at edge F and req stays high through edge F+HOLD.
- Outputs drop at edge F+HOLD+1.
- Total release latency is 3+DEBOUNCE+HOLD, which is 15 at defaults.

Beep:
- With beep_en=1, speaker_out is high for BEEP_HALF cycles, then low for BEEP_HALF cycles, repeating.
- The first high phase starts on the same edge as alert.

Throughput: all paths are single-cycle and there are no stalls.

## Test plan
1. **Defaults, steady tone (mode=0, beep_en=0):**
   - Stimulus: ui sensor_in=3'b010 held.
   - Required: speaker_out=3'b010, active_id=2 and alert=1 at edge 7.
   - Stimulus: release sensor_in.
   - Required: outputs return to 0 at edge 15 after the release.
2. **Glitch rejection:** 3-cycle pulse on sensor_in[0] → outputs never leave 0. A 4-cycle pulse → alert asserts.
3. **Priority vs multi:**
   - sensor_in=3'b110 held, mode=0 → speaker_out=3'b010, active_id=2.
   - Switch mode=1 → speaker_out=3'b110 on the next edge, active_id still 2.
4. **Hold re-trigger and beep:**
   - Sensor_in[2] falls and re-rises 5 cycles later → speaker_out[2] never drops.
   - With beep_en=1 and BEEP_HALF=16: the output toggles every 16 cycles from alert onset.
5. **Reset and ena:**
   - rst_n=0 mid-alert with ena=0 → all outputs 0 and internal counters cleared next edge.
   - ena=0 for 10 cycles during debounce → outputs 0 and the debounce count is frozen. On resume, qualification completes after the remaining cycles.
6. **Parameter sweep:** NUM_CH=1, 8, 16; DEBOUNCE=1; HOLD=0.
   - Required: latency matches 3+DEBOUNCE.
   - Required: release at 3+DEBOUNCE+HOLD.
   - Required: active_id width equals ID_W.
   - NUM_CH=16 with all inputs asserted → active_id=1.

Source files
------------

// File: rtl/obstacle_alert_encoder.sv
// N-channel obstacle alert: sync, debounce, hold stretch, priority/multi
// speaker select with optional beep gating and encoded winner report.
module obstacle_alert_encoder #(
  parameter int NUM_CH    = 3,
  parameter int DEBOUNCE  = 4,
  parameter int HOLD      = 8,
  parameter int BEEP_HALF = 16,
  localparam int ID_W     = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NUM_CH-1:0] sensor_in,
  input  logic              mode,
  input  logic              beep_en,
  output logic [NUM_CH-1:0] speaker_out,
  output logic [ID_W-1:0]   active_id,
  output logic              alert
);

  localparam int DB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int HD_W = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam int BC_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE - 1);
  localparam logic [HD_W-1:0] HD_LOAD = HD_W'(HOLD);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(BEEP_HALF - 1);

  logic [NUM_CH-1:0] sy1_q, sy1_d;
  logic [NUM_CH-1:0] sy2_q, sy2_d;
  logic [NUM_CH-1:0] det_q, det_d;

  logic [NUM_CH-1:0][DB_W-1:0] db_q, db_d;
  logic [NUM_CH-1:0][HD_W-1:0] hold_q, hold_d;

  logic [BC_W-1:0] bc_q, bc_d;
  logic            ph_q, ph_d;

  logic [NUM_CH-1:0] spk_q, spk_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic              alert_q, alert_d;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] win_oh;
  logic [NUM_CH-1:0] sel;
  logic [ID_W-1:0]   win_id;
  logic              any_req;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      req[c] = det_q[c] | (hold_q[c] != '0);
    end
    any_req = |req;
  end

  // Descending scan so the lowest requesting index wins.
  always_comb begin
    win_id = '0;
    win_oh = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (req[c]) begin
        win_id    = ID_W'(c + 1);
        win_oh    = '0;
        win_oh[c] = 1'b1;
      end
    end
    sel = mode ? req : win_oh;
  end

  always_comb begin
    sy1_d   = sy1_q;
    sy2_d   = sy2_q;
    det_d   = det_q;
    db_d    = db_q;
    hold_d  = hold_q;
    bc_d    = bc_q;
    ph_d    = ph_q;
    spk_d   = '0;
    id_d    = '0;
    alert_d = 1'b0;
    if (ena) begin
      sy1_d = sensor_in;
      sy2_d = sy1_q;
      for (int c = 0; c < NUM_CH; c++) begin
        if (sy2_q[c] == det_q[c]) begin
          db_d[c] = '0;
        end else if (db_q[c] == DB_LAST) begin
          det_d[c] = sy2_q[c];
          db_d[c]  = '0;
        end else begin
          db_d[c] = db_q[c] + DB_W'(1);
        end
        if (det_q[c]) begin
          hold_d[c] = HD_LOAD;
        end else if (hold_q[c] != '0) begin
          hold_d[c] = hold_q[c] - HD_W'(1);
        end
      end
      if (!any_req) begin
        bc_d = '0;
        ph_d = 1'b1;
      end else if (bc_q == BC_LAST) begin
        bc_d = '0;
        ph_d = ~ph_q;
      end else begin
        bc_d = bc_q + BC_W'(1);
      end
      spk_d   = sel & {NUM_CH{ph_q | ~beep_en}};
      id_d    = win_id;
      alert_d = any_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sy1_q   <= '0;
      sy2_q   <= '0;
      det_q   <= '0;
      db_q    <= '0;
      hold_q  <= '0;
      bc_q    <= '0;
      ph_q    <= 1'b1;
      spk_q   <= '0;
      id_q    <= '0;
      alert_q <= 1'b0;
    end else begin
      sy1_q   <= sy1_d;
      sy2_q   <= sy2_d;
      det_q   <= det_d;
      db_q    <= db_d;
      hold_q  <= hold_d;
      bc_q    <= bc_d;
      ph_q    <= ph_d;
      spk_q   <= spk_d;
      id_q    <= id_d;
      alert_q <= alert_d;
    end
  end

  assign speaker_out = spk_q;
  assign active_id   = id_q;
  assign alert       = alert_q;

endmodule

// File: tb/tb_obstacle_alert_encoder.sv
// Bench for obstacle_alert_encoder: directed table and sequences on the
// default build, plus a run-length reference model over four builds.
module tb_obstacle_alert_encoder;

  localparam int ND = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b0;
  logic mode = 1'b0;
  logic beep_en = 1'b0;
  logic [15:0] sens_v [ND];

  logic [2:0]  sens0, spk0;
  logic [1:0]  id0;
  logic        al0;
  logic [15:0] sens1, spk1;
  logic [4:0]  id1;
  logic        al1;
  logic [0:0]  sens2, spk2;
  logic [0:0]  id2;
  logic        al2;
  logic [7:0]  sens3, spk3;
  logic [3:0]  id3;
  logic        al3;

  assign sens0 = sens_v[0][2:0];
  assign sens1 = sens_v[1];
  assign sens2 = sens_v[2][0:0];
  assign sens3 = sens_v[3][7:0];

  always #5 clk = ~clk;

  obstacle_alert_encoder u0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_in(sens0),
    .mode(mode), .beep_en(beep_en),
    .speaker_out(spk0), .active_id(id0), .alert(al0));

  obstacle_alert_encoder #(
    .NUM_CH(16), .DEBOUNCE(1), .HOLD(0), .BEEP_HALF(3)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_in(sens1),
    .mode(mode), .beep_en(beep_en),
    .speaker_out(spk1), .active_id(id1), .alert(al1));

  obstacle_alert_encoder #(
    .NUM_CH(1), .DEBOUNCE(2), .HOLD(3), .BEEP_HALF(1)
  ) u2 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_in(sens2),
    .mode(mode), .beep_en(beep_en),
    .speaker_out(spk2), .active_id(id2), .alert(al2));

  obstacle_alert_encoder #(
    .NUM_CH(8), .DEBOUNCE(3), .HOLD(2), .BEEP_HALF(4)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sensor_in(sens3),
    .mode(mode), .beep_en(beep_en),
    .speaker_out(spk3), .active_id(id3), .alert(al3));

  int P_NC [ND] = '{3, 16, 1, 8};
  int P_DB [ND] = '{4, 1, 2, 3};
  int P_HD [ND] = '{8, 0, 3, 2};
  int P_BH [ND] = '{16, 3, 1, 4};

  int n_cmp = 0;
  int n_bad = 0;
  logic chk_on = 1'b0;

  // Model state: debounce from the run length of the synchronised level,
  // hold from cycles since the detected level was last high, beep phase
  // from cycles since alert onset.
  logic [15:0] m_sy1 [ND];
  logic [15:0] m_s   [ND];
  logic [15:0] m_det [ND];
  logic [15:0] m_lst [ND];
  int          m_run [ND][16];
  int          m_age [ND][16];
  int          m_brn [ND];
  logic [15:0] e_spk [ND];
  int          e_id  [ND];
  logic        e_al  [ND];

  localparam int BIG = 1 << 20;

  task automatic model_step(input int d);
    logic [15:0] req, sel, msk;
    int win;
    logic ph;
    logic nd;
    msk = 16'((32'd1 << P_NC[d]) - 1);
    if (!rst_n) begin
      m_sy1[d] = '0; m_s[d] = '0; m_det[d] = '0; m_lst[d] = '0;
      for (int c = 0; c < 16; c++) begin
        m_run[d][c] = 0;
        m_age[d][c] = BIG;
      end
      m_brn[d] = 0;
      e_spk[d] = '0; e_id[d] = 0; e_al[d] = 1'b0;
      return;
    end
    if (!ena) begin
      e_spk[d] = '0; e_id[d] = 0; e_al[d] = 1'b0;
      return;
    end
    req = '0;
    for (int c = 0; c < P_NC[d]; c++)
      req[c] = m_det[d][c] | (m_age[d][c] < P_HD[d]);
    win = 0;
    for (int c = P_NC[d] - 1; c >= 0; c--)
      if (req[c]) win = c + 1;
    sel = mode ? req : ((win != 0) ? (16'd1 << (win - 1)) : 16'd0);
    ph = (m_brn[d] < P_BH[d]);
    e_spk[d] = (ph || !beep_en) ? sel : 16'd0;
    e_id[d]  = win;
    e_al[d]  = (req != 0);
    m_brn[d] = (req != 0) ? (m_brn[d] + 1) % (2 * P_BH[d]) : 0;
    for (int c = 0; c < P_NC[d]; c++) begin
      if (m_run[d][c] > 0 && m_s[d][c] == m_lst[d][c])
        m_run[d][c] = (m_run[d][c] < BIG) ? m_run[d][c] + 1 : BIG;
      else
        m_run[d][c] = 1;
      m_lst[d][c] = m_s[d][c];
      nd = m_det[d][c];
      if (m_s[d][c] != m_det[d][c] && m_run[d][c] >= P_DB[d])
        nd = m_s[d][c];
      if (m_det[d][c]) m_age[d][c] = 0;
      else if (m_age[d][c] < BIG) m_age[d][c] = m_age[d][c] + 1;
      m_det[d][c] = nd;
    end
    m_s[d]   = m_sy1[d];
    m_sy1[d] = sens_v[d] & msk;
  endtask

  always @(posedge clk)
    for (int d = 0; d < ND; d++) model_step(d);

  function automatic logic [15:0] act_spk(input int d);
    case (d)
      0: return {13'd0, spk0};
      1: return spk1;
      2: return {15'd0, spk2};
      default: return {8'd0, spk3};
    endcase
  endfunction

  function automatic logic [15:0] act_id(input int d);
    case (d)
      0: return {14'd0, id0};
      1: return {11'd0, id1};
      2: return {15'd0, id2};
      default: return {12'd0, id3};
    endcase
  endfunction

  function automatic logic act_al(input int d);
    case (d)
      0: return al0;
      1: return al1;
      2: return al2;
      default: return al3;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      for (int d = 0; d < ND; d++) begin
        chk($sformatf("model_spk_d%0d", d), act_spk(d), e_spk[d]);
        chk($sformatf("model_id_d%0d", d), act_id(d), 16'(e_id[d]));
        chk($sformatf("model_alert_d%0d", d), {15'd0, act_al(d)},
            {15'd0, e_al[d]});
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ex0(input string nm, input logic [2:0] s,
                     input int id, input logic a);
    chk({nm, "_spk"}, {13'd0, spk0}, {13'd0, s});
    chk({nm, "_id"}, {14'd0, id0}, 16'(id));
    chk({nm, "_alert"}, {15'd0, al0}, {15'd0, a});
  endtask

  typedef struct {
    logic [2:0] sens;
    logic       md;
    logic [2:0] spk;
    int         id;
    logic       al;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{3'b001, 1'b0, 3'b001, 1, 1'b1};
    tbl[1] = '{3'b110, 1'b0, 3'b010, 2, 1'b1};
    tbl[2] = '{3'b110, 1'b1, 3'b110, 2, 1'b1};
    tbl[3] = '{3'b111, 1'b1, 3'b111, 1, 1'b1};
    tbl[4] = '{3'b100, 1'b1, 3'b100, 3, 1'b1};
    tbl[5] = '{3'b101, 1'b0, 3'b001, 1, 1'b1};
    tbl[6] = '{3'b000, 1'b0, 3'b000, 0, 1'b0};
    tbl[7] = '{3'b011, 1'b1, 3'b011, 1, 1'b1};

    for (int d = 0; d < ND; d++) sens_v[d] = '0;
    rst_n = 1'b0;
    ena = 1'b0;
    step(1);
    chk_on = 1'b1;
    step(1);
    ex0("reset", 3'b000, 0, 1'b0);
    rst_n = 1'b1;
    ena = 1'b1;
    step(3);

    // Detection latency and release latency at defaults.
    sens_v[0] = 16'b010;
    step(6);
    ex0("lat6", 3'b000, 0, 1'b0);
    step(1);
    ex0("lat7", 3'b010, 2, 1'b1);
    step(5);
    sens_v[0] = '0;
    step(14);
    ex0("rel14", 3'b010, 2, 1'b1);
    step(1);
    ex0("rel15", 3'b000, 0, 1'b0);
    step(5);

    // Glitch rejection and minimal accepted pulse.
    sens_v[0] = 16'b001;
    step(3);
    sens_v[0] = '0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      chk("glitch", {15'd0, al0}, 16'd0);
    end
    sens_v[0] = 16'b001;
    step(4);
    sens_v[0] = '0;
    step(3);
    ex0("pulse4", 3'b001, 1, 1'b1);
    step(30);

    // Priority then multi on the very next edge.
    sens_v[0] = 16'b110;
    step(7);
    ex0("prio", 3'b010, 2, 1'b1);
    mode = 1'b1;
    step(1);
    ex0("multi", 3'b110, 2, 1'b1);
    mode = 1'b0;
    sens_v[0] = '0;
    step(30);

    // Steady-state selection table.
    for (int r = 0; r < 8; r++) begin
      sens_v[0] = {13'd0, tbl[r].sens};
      mode = tbl[r].md;
      step(20);
      ex0($sformatf("tbl%0d", r), tbl[r].spk, tbl[r].id, tbl[r].al);
    end
    sens_v[0] = '0;
    mode = 1'b0;
    step(30);

    // Re-assertion inside the hold window.
    sens_v[0] = 16'b100;
    step(27);
    for (int i = 0; i < 25; i++) begin
      if (i == 0) sens_v[0] = '0;
      if (i == 5) sens_v[0] = 16'b100;
      step(1);
      chk("retrig", {15'd0, spk0[2]}, 16'd1);
    end
    sens_v[0] = '0;
    step(30);

    // Beep gating from alert onset.
    beep_en = 1'b1;
    sens_v[0] = 16'b001;
    step(7);
    for (int i = 0; i < 48; i++) begin
      chk("beep", {13'd0, spk0}, ((i / 16) % 2 == 0) ? 16'd1 : 16'd0);
      chk("beep_alert", {15'd0, al0}, 16'd1);
      step(1);
    end
    sens_v[0] = '0;
    beep_en = 1'b0;
    step(30);

    // Reset mid-alert with ena low clears everything.
    sens_v[0] = 16'b001;
    step(10);
    ena = 1'b0;
    rst_n = 1'b0;
    step(1);
    ex0("rst_mid", 3'b000, 0, 1'b0);
    rst_n = 1'b1;
    ena = 1'b1;
    step(1);
    ex0("rst_clr", 3'b000, 0, 1'b0);
    step(5);
    ex0("rst_e6", 3'b000, 0, 1'b0);
    step(1);
    ex0("rst_e7", 3'b001, 1, 1'b1);
    sens_v[0] = '0;
    step(30);

    // ena freeze during debounce.
    sens_v[0] = 16'b010;
    step(4);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      ex0("frz", 3'b000, 0, 1'b0);
    end
    ena = 1'b1;
    step(2);
    ex0("frz_rem", 3'b000, 0, 1'b0);
    step(1);
    ex0("frz_done", 3'b010, 2, 1'b1);
    sens_v[0] = '0;
    step(30);

    // Parameter sweep builds.
    sens_v[1] = 16'hFFFF;
    step(3);
    chk("d1_lat3", {15'd0, al1}, 16'd0);
    step(1);
    chk("d1_id_all", {11'd0, id1}, 16'd1);
    chk("d1_spk_all", spk1, 16'h0001);
    chk("d1_alert", {15'd0, al1}, 16'd1);
    sens_v[1] = '0;
    step(3);
    chk("d1_rel3", {15'd0, al1}, 16'd1);
    step(1);
    chk("d1_rel4", {15'd0, al1}, 16'd0);
    sens_v[1] = 16'h8000;
    step(4);
    chk("d1_id16", {11'd0, id1}, 16'd16);
    chk("d1_spk16", spk1, 16'h8000);
    sens_v[1] = '0;
    step(5);

    sens_v[2] = 16'd1;
    step(4);
    chk("d2_lat4", {15'd0, al2}, 16'd0);
    step(1);
    chk("d2_lat5", {15'd0, al2}, 16'd1);
    chk("d2_id", {15'd0, id2}, 16'd1);
    chk("d2_spk", {15'd0, spk2}, 16'd1);
    sens_v[2] = '0;
    step(7);
    chk("d2_rel7", {15'd0, al2}, 16'd1);
    step(1);
    chk("d2_rel8", {15'd0, al2}, 16'd0);

    mode = 1'b1;
    sens_v[3] = 16'h00A0;
    step(5);
    chk("d3_lat5", {15'd0, al3}, 16'd0);
    step(1);
    chk("d3_spk", {8'd0, spk3}, 16'h00A0);
    chk("d3_id", {12'd0, id3}, 16'd6);
    sens_v[3] = '0;
    step(7);
    chk("d3_rel7", {15'd0, al3}, 16'd1);
    step(1);
    chk("d3_rel8", {15'd0, al3}, 16'd0);
    mode = 1'b0;
    step(10);

    // Randomised traffic against the reference model.
    begin
      int rate;
      rate = 8;
      for (int t = 0; t < 3000; t++) begin
        if (t % 200 == 0) begin
          case ($urandom_range(0, 2))
            0: rate = 3;
            1: rate = 10;
            default: rate = 60;
          endcase
        end
        for (int d = 0; d < ND; d++)
          for (int c = 0; c < P_NC[d]; c++)
            if ($urandom_range(0, rate - 1) == 0)
              sens_v[d][c] = ~sens_v[d][c];
        if ($urandom_range(0, 49) == 0) mode = ~mode;
        if ($urandom_range(0, 49) == 0) beep_en = ~beep_en;
        ena = ($urandom_range(0, 19) != 0);
        rst_n = ($urandom_range(0, 499) != 0);
        step(1);
      end
    end
    rst_n = 1'b1;
    ena = 1'b1;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
